// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and data-memory wait-state controller for the 5-stage ARM pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    RA1D,
  input  logic [3:0]    RA2D,
  input  logic [3:0]    RA1E,
  input  logic [3:0]    RA2E,
  input  logic [3:0]    WA3E,
  input  logic [3:0]    WA3M,
  input  logic [3:0]    WA3W,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          PCSrcD,
  input  logic          PCSrcE,
  input  logic          PCSrcM,
  input  logic          PCSrcW,
  input  logic          BranchTakenE,
  input  logic          MemAccessM,
  input  logic          DMemReady,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushW,
  output logic          MemFault,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] waitcnt_r;
  logic [CW-1:0] waitcnt_nxt_s;
  logic          fault_r;
  logic          ldr_stall_s;
  logic          pc_pending_s;
  logic          freeze_s;

  // M-stage result wins over W; R15 (PC) is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       wr_m,
                                         input logic [3:0] wa_m,
                                         input logic       wr_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra == 4'd15) begin
      sel = 2'b00;
    end else if (wr_m && (wa_m == ra)) begin
      sel = 2'b10;
    end else if (wr_w && (wa_w == ra)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects for both E-stage operands.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    end
  end

  // Stall/flush generation; a memory freeze overrides the normal hazard rules.
  always_comb begin
    ldr_stall_s  = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
    pc_pending_s = PCSrcD | PCSrcE | PCSrcM;
    case (state_r)
      ST_RUN:   freeze_s = MemAccessM & ~DMemReady;
      ST_WAIT:  freeze_s = ~DMemReady;
      ST_FAULT: freeze_s = 1'b1;
      default:  freeze_s = 1'b1;
    endcase
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      StallF = 1'b0;
    end else if (freeze_s) begin
      // Bubble into W so the held M instruction is not written back twice.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall_s | pc_pending_s;
      StallD = ldr_stall_s;
      FlushD = pc_pending_s | PCSrcW | BranchTakenE;
      FlushE = ldr_stall_s | BranchTakenE;
    end
  end

  // Wait-state FSM next-state and watchdog counter.
  always_comb begin
    state_nxt_s   = state_r;
    waitcnt_nxt_s = waitcnt_r;
    case (state_r)
      ST_RUN: begin
        if (MemAccessM && !DMemReady) begin
          state_nxt_s   = ST_WAIT;
          waitcnt_nxt_s = ONE_C;
        end else begin
          waitcnt_nxt_s = ZERO_C;
        end
      end
      ST_WAIT: begin
        if (DMemReady) begin
          state_nxt_s   = ST_RUN;
          waitcnt_nxt_s = ZERO_C;
        end else if (waitcnt_r == TIMEOUT_C) begin
          state_nxt_s = ST_FAULT;
        end else begin
          waitcnt_nxt_s = waitcnt_r + ONE_C;
        end
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        state_nxt_s   = ST_RUN;
        waitcnt_nxt_s = ZERO_C;
      end
    endcase
  end

  // FSM state, wait counter and sticky fault register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_RUN;
      waitcnt_r <= ZERO_C;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      waitcnt_r <= waitcnt_nxt_s;
      fault_r   <= (state_nxt_s == ST_FAULT);
    end
  end

  assign MemFault = fault_r;

`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt_r;
  logic [CW-1:0] flush_cnt_r;

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= ZERO_C;
      flush_cnt_r <= ZERO_C;
    end else begin
      if (StallF && (stall_cnt_r != {CW{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + ONE_C;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((FlushD || FlushE) && (flush_cnt_r != {CW{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + ONE_C;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign StallCount = stall_cnt_r;
  assign FlushCount = flush_cnt_r;
`else
  assign StallCount = ZERO_C;
  assign FlushCount = ZERO_C;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a rule-level model.
module tb_pipeline_hazard_ctrl;
  localparam int TIMEOUT_P = 4;
  localparam int CW_P      = 4;
  localparam int MAXC      = (1 << CW_P) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemAccessM, DMemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
  logic [CW_P-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state: consecutive memory-freeze cycles, fault flag, counters
  int m_run = 0;
  bit m_fault = 1'b0;
  int m_sc = 0;
  int m_fc = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT_P), .CW(CW_P)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemAccessM(MemAccessM), .DMemReady(DMemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemFault(MemFault), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] m_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_mem_freeze();
    if (m_run > 0) return !DMemReady;
    return MemAccessM && !DMemReady;
  endfunction

  // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [10:0] m_expect();
    bit ldr, pcp, frz;
    if (!reset) return 11'd0;
    ldr = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
    pcp = PCSrcD || PCSrcE || PCSrcM;
    frz = m_fault || m_mem_freeze();
    if (frz) return {m_fwd(RA1E), m_fwd(RA2E), 7'b1111001};
    return {m_fwd(RA1E), m_fwd(RA2E), ldr | pcp, ldr, 1'b0, 1'b0,
            pcp | PCSrcW | BranchTakenE, ldr | BranchTakenE, 1'b0};
  endfunction

  // Model update on each rising edge.
  always @(posedge clk or negedge reset) begin : mdl
    logic [10:0] e;
    if (!reset) begin
      m_run <= 0; m_fault <= 1'b0; m_sc <= 0; m_fc <= 0;
    end else begin
      e = m_expect();
`ifdef HAZARD_PERF_EN
      if (e[6] && m_sc < MAXC) m_sc <= m_sc + 1;
      if ((e[2] || e[1]) && m_fc < MAXC) m_fc <= m_fc + 1;
`endif
      if (!m_fault) begin
        if (m_mem_freeze()) begin
          m_run <= m_run + 1;
          if (m_run + 1 == TIMEOUT_P + 1) m_fault <= 1'b1;
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [10:0] got, exp;
    if (chk_en) begin
      exp = m_expect();
      got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_ctrl t=%0t got %b exp %b", $time, got, exp);
      end
      checks++;
      if (MemFault !== m_fault) begin
        errors++;
        $display("FAIL model_fault t=%0t got %b exp %b", $time, MemFault, m_fault);
      end
      checks++;
      if (StallCount !== CW_P'(m_sc) || FlushCount !== CW_P'(m_fc)) begin
        errors++;
        $display("FAIL model_cnt t=%0t got %0d/%0d exp %0d/%0d", $time,
                 StallCount, FlushCount, m_sc, m_fc);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = {7{4'd0}};
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = 4'b0000;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemAccessM} = 6'b000000;
    DMemReady = 1'b1;
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 9);
    return (r < 8) ? 4'(r % 4) : 4'd15;
  endfunction

  initial begin
    int sf, fd;
    int exp_cnt;
    clear_inputs();
    next_cycle();
    chk_en = 1'b1;
    // reset: outputs forced idle even with hazardous inputs
    BranchTakenE = 1'b1; RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
    @(negedge clk);
    chk("reset_ctrl", {5'd0, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                       FlushD, FlushE, FlushW}, 16'd0);
    chk("reset_fault", {15'd0, MemFault}, 16'd0);
    next_cycle();
    reset = 1'b1;
    clear_inputs();
    next_cycle();

    // forwarding priority and R15
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    @(negedge clk);
    chk("fwd_m_prio", {14'd0, ForwardAE}, 16'h0002);
    next_cycle();
    RA1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15;
    @(negedge clk);
    chk("fwd_r15", {14'd0, ForwardAE}, 16'h0000);
    next_cycle();
    RegWriteM = 1'b0; WA3W = 4'd7; RA2E = 4'd7;
    @(negedge clk);
    chk("fwd_w", {14'd0, ForwardBE}, 16'h0001);
    next_cycle();
    clear_inputs();

    // load-use stall for exactly one cycle
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    @(negedge clk);
    chk("ldr_stall", {12'd0, StallF, StallD, StallE, FlushE}, 16'h000D);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("ldr_release", {12'd0, StallF, StallD, StallE, FlushE}, 16'h0000);
    next_cycle();

    // branch taken
    BranchTakenE = 1'b1;
    @(negedge clk);
    chk("branch_flush", {14'd0, FlushD, FlushE}, 16'h0003);
    next_cycle();
    clear_inputs();

    // PC write travelling D,E,M,W
    sf = 0; fd = 0;
    for (int i = 0; i < 5; i++) begin
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3);
      @(negedge clk);
      sf += int'(StallF); fd += int'(FlushD);
      next_cycle();
    end
    chk("pc_stallf_cycles", 16'(sf), 16'd3);
    chk("pc_flushd_cycles", 16'(fd), 16'd4);
    clear_inputs();

    // three wait states with a pending branch flush suppressed
    MemAccessM = 1'b1; DMemReady = 1'b0; BranchTakenE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mem_freeze", {9'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
          16'h0079);
      next_cycle();
    end
    DMemReady = 1'b1;
    @(negedge clk);
    chk("mem_resume", {12'd0, StallE, FlushD, FlushE, MemFault}, 16'h0006);
    next_cycle();
    clear_inputs();

    // watchdog: TIMEOUT+1 frozen cycles then sticky fault
    MemAccessM = 1'b1; DMemReady = 1'b0;
    for (int i = 0; i < TIMEOUT_P + 1; i++) begin
      @(negedge clk);
      chk("fault_not_yet", {15'd0, MemFault}, 16'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("fault_set", {15'd0, MemFault}, 16'd1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("fault_sticky", {14'd0, MemFault, StallF}, 16'h0003);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("fault_reset", {14'd0, MemFault, StallF}, 16'h0000);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_run", {12'd0, StallF, StallM, FlushW, MemFault}, 16'h0000);
    next_cycle();

    // counter saturation with 20 load-use stall cycles
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    repeat (20) next_cycle();
    clear_inputs();
`ifdef HAZARD_PERF_EN
    exp_cnt = MAXC;
`else
    exp_cnt = 0;
`endif
    @(negedge clk);
    chk("stall_count_sat", 16'(StallCount), 16'(exp_cnt));
    chk("flush_count_sat", 16'(FlushCount), 16'(exp_cnt));
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 149) == 0) reset = 1'b0;
      RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
      WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 9) == 0); PCSrcE = ($urandom_range(0, 9) == 0);
      PCSrcM = ($urandom_range(0, 9) == 0); PCSrcW = ($urandom_range(0, 9) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemAccessM = ($urandom_range(0, 2) == 0);
      DMemReady = ($urandom_range(0, 3) != 0);
      next_cycle();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
